// File: rtl/xvga_timing_gen.sv
// Raster timing generator: hcount/vcount scan position, sync/blank strobes,
// and a delayed copy of the strobes aligned with the renderers' pixel output.
module xvga_timing_gen #(
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter int SYNC_DELAY = 3
) (
  input  logic        pixel_clk,
  input  logic        reset,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  output logic        hsync_d,
  output logic        vsync_d,
  output logic        blank_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_next;
  logic [9:0]  v_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        blank_next;
  logic        frame_start_next;

  // Strobes are decoded from the next counter values so that once registered
  // they line up exactly with the counters; any out-of-range count wraps to 0.
  always_comb begin
    h_next = hcount + 11'd1;
    v_next = vcount;
    if (hcount >= H_LAST) begin
      h_next = 11'd0;
      if (vcount >= V_LAST) v_next = 10'd0;
      else                  v_next = vcount + 10'd1;
    end else if (vcount > V_LAST) begin
      v_next = 10'd0;
    end
    hsync_next       = !((h_next >= HS_START) && (h_next < HS_END));
    vsync_next       = !((v_next >= VS_START) && (v_next < VS_END));
    blank_next       = (h_next >= H_ACT) || (v_next >= V_ACT);
    frame_start_next = (h_next == 11'd0) && (v_next == 10'd0);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hcount      <= 11'd0;
      vcount      <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank       <= 1'b0;
      frame_start <= 1'b1;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      blank       <= blank_next;
      frame_start <= frame_start_next;
    end
  end

  // Stage 0 takes the registered strobes, so stage N-1 lags them by N cycles.
  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hsync_d = hsync;
      assign vsync_d = vsync;
      assign blank_d = blank;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0][2:0] pipe;

      always_ff @(posedge pixel_clk) begin
        if (reset) begin
          for (int i = 0; i < SYNC_DELAY; i++) pipe[i] <= 3'b110;
        end else begin
          pipe[0] <= {hsync, vsync, blank};
          for (int i = 1; i < SYNC_DELAY; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign hsync_d = pipe[SYNC_DELAY-1][2];
      assign vsync_d = pipe[SYNC_DELAY-1][1];
      assign blank_d = pipe[SYNC_DELAY-1][0];
    end
  endgenerate

endmodule

// File: tb/tb_xvga_timing_gen.sv
// Randomised-reset bench for xvga_timing_gen: three instances (default timing,
// small timing with delay 3, small timing with delay 0) against an arithmetic model.
module tb_xvga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, d;
  } cfg_t;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs, vs, bl, fs, hsd, vsd, bld;
  } obs_t;

  cfg_t cfg_big = '{1024, 24, 136, 160, 768, 3, 6, 29, 3};
  cfg_t cfg_sml = '{16, 2, 3, 4, 8, 1, 2, 2, 3};
  cfg_t cfg_zer = '{16, 2, 3, 4, 8, 1, 2, 2, 0};

  logic pixel_clk = 1'b0;
  logic reset = 1'b1;

  logic [10:0] hcount_b, hcount_s, hcount_z;
  logic [9:0]  vcount_b, vcount_s, vcount_z;
  logic hsync_b, vsync_b, blank_b, fs_b, hsd_b, vsd_b, bld_b;
  logic hsync_s, vsync_s, blank_s, fs_s, hsd_s, vsd_s, bld_s;
  logic hsync_z, vsync_z, blank_z, fs_z, hsd_z, vsd_z, bld_z;

  int checks_total = 0;
  int checks_passed = 0;
  longint k = 0;
  logic model_ok = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  xvga_timing_gen dut_big (
    .pixel_clk(pixel_clk), .reset(reset), .hcount(hcount_b), .vcount(vcount_b),
    .hsync(hsync_b), .vsync(vsync_b), .blank(blank_b), .frame_start(fs_b),
    .hsync_d(hsd_b), .vsync_d(vsd_b), .blank_d(bld_b)
  );

  xvga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_DELAY(3)
  ) dut_sml (
    .pixel_clk(pixel_clk), .reset(reset), .hcount(hcount_s), .vcount(vcount_s),
    .hsync(hsync_s), .vsync(vsync_s), .blank(blank_s), .frame_start(fs_s),
    .hsync_d(hsd_s), .vsync_d(vsd_s), .blank_d(bld_s)
  );

  xvga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_DELAY(0)
  ) dut_zer (
    .pixel_clk(pixel_clk), .reset(reset), .hcount(hcount_z), .vcount(vcount_z),
    .hsync(hsync_z), .vsync(vsync_z), .blank(blank_z), .frame_start(fs_z),
    .hsync_d(hsd_z), .vsync_d(vsd_z), .blank_d(bld_z)
  );

  // Strobes at k cycles after the last reset edge, straight from the raster rules.
  function automatic logic [2:0] strobes_at(cfg_t c, longint kk);
    longint ht = c.ha + c.hf + c.hs + c.hb;
    longint vt = c.va + c.vf + c.vs + c.vb;
    longint h = kk % ht;
    longint v = (kk / ht) % vt;
    logic hs_v, vs_v, bl_v;
    hs_v = !((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs));
    vs_v = !((v >= c.va + c.vf) && (v < c.va + c.vf + c.vs));
    bl_v = (h >= c.ha) || (v >= c.va);
    return {hs_v, vs_v, bl_v};
  endfunction

  function automatic obs_t model_at(cfg_t c, longint kk);
    longint ht = c.ha + c.hf + c.hs + c.hb;
    longint vt = c.va + c.vf + c.vs + c.vb;
    longint h = kk % ht;
    longint v = (kk / ht) % vt;
    obs_t r;
    r.h = 11'(h);
    r.v = 10'(v);
    {r.hs, r.vs, r.bl} = strobes_at(c, kk);
    r.fs = (h == 0) && (v == 0);
    if (kk >= c.d) {r.hsd, r.vsd, r.bld} = strobes_at(c, kk - c.d);
    else           {r.hsd, r.vsd, r.bld} = 3'b110;
    return r;
  endfunction

  task automatic check_field(input string name, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (k=%0d)", name, act, exp, k);
  endtask

  task automatic check_output(input string tag, input obs_t act, input obs_t e);
    check_field({tag, ".hcount"},  act.h,   e.h);
    check_field({tag, ".vcount"},  act.v,   e.v);
    check_field({tag, ".hsync"},   act.hs,  e.hs);
    check_field({tag, ".vsync"},   act.vs,  e.vs);
    check_field({tag, ".blank"},   act.bl,  e.bl);
    check_field({tag, ".frame"},   act.fs,  e.fs);
    check_field({tag, ".hsync_d"}, act.hsd, e.hsd);
    check_field({tag, ".vsync_d"}, act.vsd, e.vsd);
    check_field({tag, ".blank_d"}, act.bld, e.bld);
  endtask

  // Cycles elapsed since the most recent reset edge drive the whole model.
  always @(posedge pixel_clk) begin
    if (reset) begin
      k <= 0;
      model_ok <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  always @(negedge pixel_clk) begin
    if (model_ok) begin
      check_output("big", {hcount_b, vcount_b, hsync_b, vsync_b, blank_b, fs_b, hsd_b, vsd_b, bld_b},
                   model_at(cfg_big, k));
      check_output("sml", {hcount_s, vcount_s, hsync_s, vsync_s, blank_s, fs_s, hsd_s, vsd_s, bld_s},
                   model_at(cfg_sml, k));
      check_output("zer", {hcount_z, vcount_z, hsync_z, vsync_z, blank_z, fs_z, hsd_z, vsd_z, bld_z},
                   model_at(cfg_zer, k));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pixel_clk);
    #1;
  endtask

  task automatic apply_stimulus();
    int fs_count_s;
    int fs_count_z;

    // Reset held for five cycles.
    reset = 1'b1;
    tick(5);
    check_field("lit_rst_hcount", hcount_b, 0);
    check_field("lit_rst_vcount", vcount_b, 0);
    check_field("lit_rst_hsync", hsync_b, 1);
    check_field("lit_rst_vsync", vsync_b, 1);
    check_field("lit_rst_blank", blank_b, 0);
    check_field("lit_rst_frame", fs_b, 1);
    check_field("lit_rst_hsync_d", hsd_b, 1);
    check_field("lit_rst_blank_d", bld_b, 0);
    reset = 1'b0;
    tick(1);
    check_field("lit_rel_hcount", hcount_b, 1);
    check_field("lit_rel_frame", fs_b, 0);

    // End of line 10 and wrap into line 11 on the default raster.
    tick(14782);
    check_field("lit_eol_hcount", hcount_b, 1343);
    check_field("lit_eol_vcount", vcount_b, 10);
    check_field("lit_eol_blank", blank_b, 1);
    tick(1);
    check_field("lit_wrap_hcount", hcount_b, 0);
    check_field("lit_wrap_vcount", vcount_b, 11);
    check_field("lit_wrap_blank", blank_b, 0);

    // hsync edges within line 11 and the 3-cycle lag of hsync_d.
    tick(1047);
    check_field("lit_h1047_hsync", hsync_b, 1);
    tick(1);
    check_field("lit_h1048_hsync", hsync_b, 0);
    check_field("lit_h1048_hsync_d", hsd_b, 1);
    tick(2);
    check_field("lit_h1050_hsync_d", hsd_b, 1);
    tick(1);
    check_field("lit_h1051_hsync_d", hsd_b, 0);
    tick(132);
    check_field("lit_h1183_hsync", hsync_b, 0);
    tick(1);
    check_field("lit_h1184_hsync", hsync_b, 1);

    // Any window of three small frames holds exactly three frame_start pulses.
    fs_count_s = 0;
    fs_count_z = 0;
    for (int i = 0; i < 3 * 325; i++) begin
      tick(1);
      if (fs_s) fs_count_s++;
      if (fs_z) fs_count_z++;
    end
    check_field("lit_sml_frames", fs_count_s, 3);
    check_field("lit_zer_frames", fs_count_z, 3);

    // One-cycle reset while both syncs of the small raster are low.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(244);
    check_field("lit_mid_hcount", hcount_s, 19);
    check_field("lit_mid_vcount", vcount_s, 9);
    check_field("lit_mid_hsync", hsync_s, 0);
    check_field("lit_mid_vsync", vsync_s, 0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_field("lit_mid_rst_hcount", hcount_s, 0);
    check_field("lit_mid_rst_vcount", vcount_s, 0);
    check_field("lit_mid_rst_hsync_d", hsd_s, 1);
    check_field("lit_mid_rst_vsync_d", vsd_s, 1);
    check_field("lit_mid_rst_blank_d", bld_s, 0);
    check_field("lit_mid_rst_frame", fs_s, 1);
    tick(3);
    check_field("lit_mid_flush_hsync_d", hsd_s, 1);
    check_field("lit_mid_flush_vsync_d", vsd_s, 1);

    // Random run lengths with occasional resets of random length.
    for (int i = 0; i < 40; i++) begin
      tick($urandom_range(1, 700));
      if ($urandom_range(0, 3) == 0) begin
        reset = 1'b1;
        tick($urandom_range(1, 3));
        reset = 1'b0;
      end
    end
    tick(400);
  endtask

  initial begin
    apply_stimulus();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
